id_ex_stage: RTL

//  ID/EX pipeline register sitting directly downstream of the instruction decoder.

---
 rtl/id_ex_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Holds the decoded instruction for execute, inserts one
// bubble per load-use hazard, and honours execute-side hold and branch flush.
module id_ex_stage #(
    parameter logic [5:0] LOAD_OPCODE = 6'h0A,
    parameter int         PC_W        = 16,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ex_stall,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic [9:0]       id_imm10,
    input  logic [14:0]      id_imm15,
    input  logic [19:0]      id_imm20,
    input  logic [PC_W-1:0]  id_pc,
    output logic             ex_valid,
    output logic [5:0]       ex_opcode,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_rn,
    output logic [4:0]       ex_rm,
    output logic [9:0]       ex_imm10,
    output logic [14:0]      ex_imm15,
    output logic [19:0]      ex_imm20,
    output logic [PC_W-1:0]  ex_pc,
    output logic             id_stall,
    output logic [CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic [5:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rn;
        logic [4:0]      rm;
        logic [9:0]      imm10;
        logic [14:0]     imm15;
        logic [19:0]     imm20;
        logic [PC_W-1:0] pc;
    } fields_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fields_t          fields_q, fields_d, id_fields;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic             load_use;

    assign id_fields = '{opcode: id_opcode, rd: id_rd, rn: id_rn, rm: id_rm,
                         imm10: id_imm10, imm15: id_imm15, imm20: id_imm20, pc: id_pc};

    // A load sitting in EX whose destination feeds either source of the decoder's instruction.
    assign load_use = valid_q & (fields_q.opcode == LOAD_OPCODE) & id_valid &
                      ((fields_q.rd == id_rn) | (fields_q.rd == id_rm));

    // Gated by rst so upstream never sees a stall while the stage is being cleared.
    assign id_stall = ~rst & ~flush & (ex_stall | load_use);

    always_comb begin
        fields_d = fields_q;
        valid_d  = valid_q;
        bubble_d = bubble_q;
        if (flush) begin
            valid_d  = 1'b0;
            fields_d = '0;
        end else if (ex_stall) begin
            valid_d  = valid_q;
            fields_d = fields_q;
        end else if (load_use) begin
            valid_d  = 1'b0;
            fields_d = '0;
            if (~&bubble_q) begin
                bubble_d = bubble_q + CNT_ONE;
            end
        end else begin
            valid_d  = id_valid;
            fields_d = id_valid ? id_fields : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            fields_q <= '0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            fields_q <= fields_d;
            bubble_q <= bubble_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_opcode    = fields_q.opcode;
    assign ex_rd        = fields_q.rd;
    assign ex_rn        = fields_q.rn;
    assign ex_rm        = fields_q.rm;
    assign ex_imm10     = fields_q.imm10;
    assign ex_imm15     = fields_q.imm15;
    assign ex_imm20     = fields_q.imm20;
    assign ex_pc        = fields_q.pc;
    assign bubble_count = bubble_q;

endmodule
